// File: rtl/cic_decimator.sv
// CIC (Hogenauer) decimator: M integrators at input rate, decimate by R,
// M combs (differential delay G) at output rate, output truncated to odw MSBs.
module cic_decimator #(
    parameter int idw = 16,
    parameter int odw = 16,
    parameter int R   = 25,
    parameter int M   = 4,
    parameter int G   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [idw-1:0] data_in,
    output logic signed [odw-1:0] data_out,
    output logic                  out_dv
);

    localparam int B  = M * $clog2(R * G);
    localparam int W  = idw + B;
    localparam int CW = $clog2(R);

    logic [W-1:0]  x_ext;
    logic [W-1:0]  integ  [1:M];
    logic [W-1:0]  comb_s [0:M];
    logic [W-1:0]  dly    [1:M][0:G-1];
    logic [CW-1:0] cnt;
    logic          strobe;

    // Sign-extend the input to the full internal width; growth bits absorb the gain.
    assign x_ext  = {{B{data_in[idw-1]}}, data_in};
    assign strobe = (cnt == CW'(R - 1));

    // Phase counter: strobe on the last phase of each R-sample block.
    always_ff @(posedge clk) begin
        if (reset)       cnt <= '0;
        else if (strobe) cnt <= '0;
        else             cnt <= cnt + CW'(1);
    end

    // Integrator cascade; modular wrap is deliberate and cancelled by the combs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= M; k++) integ[k] <= '0;
        end else begin
            integ[1] <= integ[1] + x_ext;
            for (int k = 2; k <= M; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Comb chain is purely combinational, evaluated in the strobe cycle.
    assign comb_s[0] = integ[M];
    for (genvar k = 1; k <= M; k++) begin : g_comb
        assign comb_s[k] = comb_s[k-1] - dly[k][G-1];
    end

    // Comb delay lines advance once per output sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= M; k++)
                for (int j = 0; j < G; j++) dly[k][j] <= '0;
        end else if (strobe) begin
            for (int k = 1; k <= M; k++) begin
                dly[k][0] <= comb_s[k-1];
                for (int j = 1; j < G; j++) dly[k][j] <= dly[k][j-1];
            end
        end
    end

    // Output register: arithmetic shift keeps the MSBs (floor toward -inf).
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            out_dv   <= 1'b0;
        end else begin
            out_dv <= strobe;
            if (strobe) data_out <= odw'($signed(comb_s[M]) >>> (W - odw));
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: reset/cadence, DC table via scoreboard, Nyquist, tone, mid-run reset.
module tb_cic_decimator;

    localparam int R = 25;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] data_in;
    logic signed [15:0] data_out;
    logic               out_dv;

    cic_decimator #(.idw(16), .odw(16), .R(R), .M(4), .G(1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_out(data_out), .out_dv(out_dv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] din;
        logic signed [15:0] expv;
    } vec_t;

    vec_t vecs [5];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic signed [15:0] sb [$];

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard consumer: compares each output strobe against queued expectations.
    always @(negedge clk) begin
        if (!reset && out_dv && sb.size() > 0) check("dc_out", int'(data_out), int'(sb.pop_front()));
    end

    // Wait for n out_dv pulses with a cycle budget.
    task automatic wait_pulses(input int n, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < (n + 4) * R) begin
            @(negedge clk);
            cyc++;
            if (out_dv) seen++;
        end
        if (seen < n) fail_timeout(name);
    endtask

    // Queue expected values and wait until the monitor consumed them.
    task automatic dc_check(input logic signed [15:0] din, input logic signed [15:0] expv);
        int cyc = 0;
        data_in = din;
        wait_pulses(10, "dc_settle");
        repeat (3) sb.push_back(expv);
        while (sb.size() > 0 && cyc < 8 * R) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() > 0) begin
            fail_timeout("dc_drain");
            sb.delete();
        end
    endtask

    // Count clocks from release to first pulse, then pulse width and period.
    task automatic check_cadence(input string name);
        int k = 0;
        while (!out_dv && k <= 3 * R) begin
            @(negedge clk);
            k++;
        end
        check({name, "_first_dv"}, k, R);
        k = 0;
        @(negedge clk);
        k++;
        check({name, "_dv_width"}, int'(out_dv), 0);
        while (!out_dv && k <= 3 * R) begin
            @(negedge clk);
            k++;
        end
        check({name, "_period"}, k, R);
    endtask

    initial begin
        int peak;
        int v;
        vecs[0] = '{din: 16'sd1000,   expv: 16'sd372};
        vecs[1] = '{din: -16'sd1000,  expv: -16'sd373};
        vecs[2] = '{din: 16'sd32767,  expv: 16'sd12206};
        vecs[3] = '{din: -16'sd32768, expv: -16'sd12208};
        vecs[4] = '{din: 16'sd0,      expv: 16'sd0};

        // Reset held 5 clocks: outputs stay cleared.
        reset = 1'b1;
        data_in = 16'sd1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_data_out", int'(data_out), 0);
            check("reset_out_dv", int'(out_dv), 0);
        end
        reset = 1'b0;
        check_cadence("reset");

        // DC table, including full scale where the integrators wrap.
        for (int i = 0; i < 5; i++) dc_check(vecs[i].din, vecs[i].expv);

        // Nyquist alternation lands in the stopband.
        for (int i = 0; i < 40 * R; i++) begin
            @(negedge clk);
            data_in = (i % 2 == 0) ? 16'sd32767 : -16'sd32767;
            if (out_dv && i > 15 * R) begin
                v = int'(data_out);
                if (v > 1 || v < -1) check("nyquist_stopband", v, 0);
                else n_cmp++;
            end
        end

        // Tone: track peak after settling, then reset mid-run.
        peak = 0;
        for (int n = 0; n < 130 * R; n++) begin
            @(negedge clk);
            data_in = 16'(int'(32767.0 * $sin(0.005 * n)));
            if (out_dv && n > 12 * R) begin
                v = int'(data_out);
                if (v < 0) v = -v;
                if (v > peak) peak = v;
            end
        end
        n_cmp++;
        if (peak < 12100 || peak > 12206) begin
            n_bad++;
            $display("FAIL tone_peak: got %0d, expected in [12100,12206]", peak);
        end

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_data_out", int'(data_out), 0);
        check("midreset_out_dv", int'(out_dv), 0);
        check_cadence("midreset");
        dc_check(16'sd1000, 16'sd372);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
